// File: rtl/jtframe_db9_scan.sv
`timescale 1ns/1ps
// DB9 joystick chain scanner: loads and clocks a 74HC165-style chain, shifts in
// 16 active-low button bits, optionally debounces, and publishes active-high words.
module jtframe_db9_scan #(
  parameter int CLKDIV      = 4,
  parameter int SCAN_PERIOD = 4096,
  parameter int DEBOUNCE    = 1
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        en,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  input  logic        JOY_DATA,
  output logic [31:0] joystick1,
  output logic [31:0] joystick2,
  output logic        scan_done
);

  // state      | meaning
  // S_IDLE     | waiting for en and the scan period to elapse
  // S_LOAD     | JOY_LOAD low, chain captures the buttons
  // S_SETUP    | JOY_LOAD back high, first bit settles on Q_H
  // S_SHIFT_LO | JOY_CLK low, data sampled on the last cycle
  // S_SHIFT_HI | JOY_CLK high, chain advances one bit
  // S_DONE     | one cycle: debounce compare and publish
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(SCAN_PERIOD - 1);

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] per_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   raw;
  logic [15:0]   prev_cand;
  logic          first;
  logic          tick;
  logic [15:0]   cand;

  assign tick = (div_cnt == DIV_LAST);
  assign cand = ~raw;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      per_cnt   <= '0;
      bit_cnt   <= '0;
      raw       <= 16'hFFFF;
      prev_cand <= '0;
      first     <= 1'b1;
      JOY_CLK   <= 1'b0;
      JOY_LOAD  <= 1'b1;
      joystick1 <= '0;
      joystick2 <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      first     <= 1'b0;
      // saturates so a short SCAN_PERIOD cannot wrap during a long scan
      if (per_cnt != PER_LAST) per_cnt <= per_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (en && (first || per_cnt == PER_LAST)) begin
            state    <= S_LOAD;
            per_cnt  <= '0;
            JOY_LOAD <= 1'b0;
          end
        end

        S_LOAD: begin
          if (tick) begin
            state    <= S_SETUP;
            div_cnt  <= '0;
            JOY_LOAD <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_SETUP: begin
          bit_cnt <= '0;
          if (tick) begin
            state   <= S_SHIFT_LO;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_SHIFT_LO: begin
          if (tick) begin
            raw[4'd15 - bit_cnt] <= JOY_DATA;
            state   <= S_SHIFT_HI;
            div_cnt <= '0;
            JOY_CLK <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_SHIFT_HI: begin
          if (tick) begin
            div_cnt <= '0;
            JOY_CLK <= 1'b0;
            if (bit_cnt == 4'd15) begin
              state <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= S_SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_DONE: begin
          scan_done <= 1'b1;
          div_cnt   <= '0;
          if (DEBOUNCE == 0 || cand == prev_cand) begin
            joystick1 <= {24'd0, cand[15:8]};
            joystick2 <= {24'd0, cand[7:0]};
          end
          prev_cand <= cand;
          state     <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          div_cnt  <= '0;
          JOY_CLK  <= 1'b0;
          JOY_LOAD <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_db9_scan.sv
`timescale 1ns/1ps
// Bench for jtframe_db9_scan: two instances (plain and debounced) driven by
// behavioural 165 chain models, with table vectors and a randomized debounce run.
module tb_jtframe_db9_scan;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst_a, en_a, jclk_a, jload_a, jdata_a, done_a;
  logic [31:0] j1_a, j2_a;
  logic        rst_b, en_b, jclk_b, jload_b, jdata_b, done_b;
  logic [31:0] j1_b, j2_b;

  jtframe_db9_scan #(.CLKDIV(4), .SCAN_PERIOD(200), .DEBOUNCE(0)) u_a (
    .clk_sys(clk_sys), .rst_n(rst_a), .en(en_a),
    .JOY_CLK(jclk_a), .JOY_LOAD(jload_a), .JOY_DATA(jdata_a),
    .joystick1(j1_a), .joystick2(j2_a), .scan_done(done_a)
  );

  jtframe_db9_scan #(.CLKDIV(3), .SCAN_PERIOD(50), .DEBOUNCE(1)) u_b (
    .clk_sys(clk_sys), .rst_n(rst_b), .en(en_b),
    .JOY_CLK(jclk_b), .JOY_LOAD(jload_b), .JOY_DATA(jdata_b),
    .joystick1(j1_b), .joystick2(j2_b), .scan_done(done_b)
  );

  // 165 chain models: parallel load while JOY_LOAD low, shift toward Q_H on JOY_CLK rise
  logic [15:0] val_a = 16'hFFFF, sr_a = 16'hFFFF, val_b = 16'hFFFF, sr_b = 16'hFFFF;
  logic        pclk_a = 1'b0, pclk_b = 1'b0;
  assign jdata_a = sr_a[15];
  assign jdata_b = sr_b[15];

  always @(negedge clk_sys) begin
    if (!jload_a) sr_a <= val_a;
    else if (jclk_a && !pclk_a) sr_a <= {sr_a[14:0], 1'b1};
    pclk_a <= jclk_a;
    if (!jload_b) sr_b <= val_b;
    else if (jclk_b && !pclk_b) sr_b <= {sr_b[14:0], 1'b1};
    pclk_b <= jclk_b;
  end

  // waveform monitors
  int   cyc = 0;
  int   falls_a[$];
  int   rises_a = 0, hi_len_a = 0, lo_len_a = 0, load_lo_a = 0, load_len_a = 0;
  int   width_err_a = 0, both_chg_a = 0, both_chg_b = 0;
  int   fall_cyc_a = 0, lat_a = 0, fall_cyc_b = 0, lat_b = 0;
  logic pl_a = 1'b1, pc_a = 1'b0, pl_b = 1'b1, pc_b = 1'b0;

  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    if (pl_a && !jload_a) begin
      falls_a.push_back(cyc);
      fall_cyc_a = cyc;
      rises_a = 0;
    end
    if (!jload_a) load_lo_a = load_lo_a + 1;
    else if (!pl_a) begin
      load_len_a = load_lo_a;
      load_lo_a = 0;
    end
    if (jclk_a) begin
      if (!pc_a) begin
        rises_a = rises_a + 1;
        if (rises_a > 1 && lo_len_a != 4) width_err_a = width_err_a + 1;
      end
      hi_len_a = hi_len_a + 1;
      lo_len_a = 0;
    end else begin
      if (pc_a && hi_len_a != 4) width_err_a = width_err_a + 1;
      lo_len_a = lo_len_a + 1;
      hi_len_a = 0;
    end
    if (jclk_a != pc_a && jload_a != pl_a) both_chg_a = both_chg_a + 1;
    if (done_a) lat_a = cyc - fall_cyc_a;
    pc_a = jclk_a;
    pl_a = jload_a;

    if (pl_b && !jload_b) fall_cyc_b = cyc;
    if (jclk_b != pc_b && jload_b != pl_b) both_chg_b = both_chg_b + 1;
    if (done_b) lat_b = cyc - fall_cyc_b;
    pc_b = jclk_b;
    pl_b = jload_b;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_done(input int sel, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if ((sel == 0 && done_a) || (sel == 1 && done_b)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // reference for the debounced instance: history of scanned button words
  logic [15:0] hist[$];
  logic [31:0] m1 = 32'd0, m2 = 32'd0;

  task automatic scan_b(input logic [15:0] v);
    bit ok;
    logic [15:0] pressed;
    val_b = v;
    wait_done(1, 400, ok);
    check("b_scan_done", ok, 1'b1);
    tick();
    check("b_back_to_back_load", jload_b, 1'b0);
    pressed = ~v;
    hist.push_back(pressed);
    if (hist[hist.size()-1] == hist[hist.size()-2]) begin
      m1 = pressed[15:8];
      m2 = pressed[7:0];
    end
  endtask

  typedef struct {
    logic [15:0] val;
    logic [31:0] j1;
    logic [31:0] j2;
  } vec_t;

  vec_t tbl_a[6];
  vec_t tbl_b[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, bad;
    int n0, n1;
    logic [15:0] v, lastv;

    tbl_a[0] = '{16'hFFFF, 32'h00, 32'h00};
    tbl_a[1] = '{16'h0000, 32'hFF, 32'hFF};
    tbl_a[2] = '{16'h7FFE, 32'h80, 32'h01};
    tbl_a[3] = '{16'hAA55, 32'h55, 32'hAA};
    tbl_a[4] = '{16'hFBDF, 32'h04, 32'h20};
    tbl_a[5] = '{16'h0FF0, 32'hF0, 32'h0F};

    tbl_b[0] = '{16'hFEFF, 32'h00, 32'h00};
    tbl_b[1] = '{16'hFFFF, 32'h00, 32'h00};
    tbl_b[2] = '{16'hFFFF, 32'h00, 32'h00};
    tbl_b[3] = '{16'hFEFF, 32'h00, 32'h00};
    tbl_b[4] = '{16'hFEFF, 32'h01, 32'h00};

    hist.push_back(16'h0000);

    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    repeat (5) tick();
    check("rst_load", jload_a, 1'b1);
    check("rst_clk", jclk_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_j1", j1_a, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;

    bad = 1'b0;
    repeat (500) begin
      tick();
      if (jload_a !== 1'b1 || jclk_a !== 1'b0 || done_a !== 1'b0 || j1_a !== 0 || j2_a !== 0)
        bad = 1'b1;
    end
    check("idle_quiet", bad, 1'b0);

    // single scan with timing
    val_a = 16'hFE7F;
    falls_a.delete();
    en_a = 1'b1;
    tick();
    check("load_on_enable", jload_a, 1'b0);
    wait_done(0, 400, ok);
    check("single_done", ok, 1'b1);
    check("load_to_done", lat_a, 137);
    check("load_low_len", load_len_a, 4);
    check("clk_pulses", rises_a, 16);
    tick();
    check("single_j1", j1_a, 32'h01);
    check("single_j2", j2_a, 32'h80);

    for (int i = 0; i < 6; i++) begin
      val_a = tbl_a[i].val;
      wait_done(0, 600, ok);
      check("tbl_a_done", ok, 1'b1);
      tick();
      check($sformatf("tbl_a_j1[%0d]", i), j1_a, tbl_a[i].j1);
      check($sformatf("tbl_a_j2[%0d]", i), j2_a, tbl_a[i].j2);
    end

    check("period_scans", falls_a.size(), 7);
    bad = 1'b0;
    for (int i = 1; i < falls_a.size(); i++)
      if (falls_a[i] - falls_a[i-1] != 200) bad = 1'b1;
    check("period_200", bad, 1'b0);
    check("clk_widths", width_err_a, 0);
    check("a_load_clk_same_cycle", both_chg_a, 0);

    // en dropped while bit 5 is on the chain
    n0 = falls_a.size();
    for (int i = 0; i < 400 && falls_a.size() == n0; i++) tick();
    for (int i = 0; i < 200 && rises_a < 6; i++) tick();
    check("reach_bit5", rises_a, 6);
    en_a = 1'b0;
    wait_done(0, 300, ok);
    check("en_drop_done", ok, 1'b1);
    n1 = falls_a.size();
    repeat (400) tick();
    check("no_load_after_en_drop", falls_a.size(), n1);
    en_a = 1'b1;
    tick();
    check("load_on_en_rise", jload_a, 1'b0);

    // reset while bit 9 is on the chain
    for (int i = 0; i < 300 && rises_a < 10; i++) tick();
    check("reach_bit9_high", jclk_a, 1'b1);
    check("pre_reset_j1", j1_a, 32'hF0);
    rst_a = 1'b0;
    #1;
    check("mid_rst_clk", jclk_a, 1'b0);
    check("mid_rst_load", jload_a, 1'b1);
    check("mid_rst_j1", j1_a, 32'd0);
    check("mid_rst_j2", j2_a, 32'd0);
    check("mid_rst_done", done_a, 1'b0);
    val_a = 16'h5AA5;
    repeat (3) tick();
    rst_a = 1'b1;
    wait_done(0, 400, ok);
    check("post_rst_done", ok, 1'b1);
    check("post_rst_latency", lat_a, 137);
    tick();
    check("post_rst_j1", j1_a, 32'hA5);
    check("post_rst_j2", j2_a, 32'h5A);

    // debounced instance, back-to-back scans
    val_b = tbl_b[0].val;
    en_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      scan_b(tbl_b[i].val);
      if (i == 0) check("b_load_to_done", lat_b, 103);
      check($sformatf("tbl_b_j1[%0d]", i), j1_b, tbl_b[i].j1);
      check($sformatf("tbl_b_j2[%0d]", i), j2_b, tbl_b[i].j2);
    end

    lastv = 16'hFEFF;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) v = lastv;
      else v = 16'($urandom);
      scan_b(v);
      check($sformatf("rand_j1[%0d]", i), j1_b, m1);
      check($sformatf("rand_j2[%0d]", i), j2_b, m2);
      lastv = v;
    end
    check("b_load_clk_same_cycle", both_chg_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
